// File: rtl/stb_sampler_if.sv
// Software control/readout bundle for stb_sampler.
//   start_i      : single-cycle acquisition request (master -> slave)
//   n_samples_i  : number of strobe edges to sample, latched on accepted start
//   busy_o       : acquisition in progress (slave -> master)
//   done_o       : one-cycle pulse at the end of an acquisition
//   err_o        : sticky error of the last acquisition
//   hit_cnt_o    : samples that read 1 in the last acquisition
//   total_cnt_o  : samples taken in the last acquisition
interface stb_sampler_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start_i;
    logic [CNT_W-1:0] n_samples_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [CNT_W-1:0] hit_cnt_o;
    logic [CNT_W-1:0] total_cnt_o;

    modport master (
        output start_i, n_samples_i,
        input  busy_o, done_o, err_o, hit_cnt_o, total_cnt_o
    );

    modport slave (
        input  start_i, n_samples_i,
        output busy_o, done_o, err_o, hit_cnt_o, total_cnt_o
    );
endinterface

// File: rtl/stb_sampler.sv
// Strobe-driven comparator sampler. On each rising edge of the strobe it
// samples the synchronised comparator output and accumulates hit/total
// counts over a programmed number of strobes. A watchdog aborts the
// acquisition when the strobe stalls or never arrives.
//   clk_i      : system clock
//   arst_i     : asynchronous active-high reset
//   stb_rdy_i  : strobe generator locked
//   stb_i      : strobe, synchronous to clk_i
//   cmp_i      : comparator output, asynchronous
//   ctl        : software handshake and readout (stb_sampler_if.slave)
// TIMEOUT_CYCLES must be at least 2.
module stb_sampler #(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_W      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 32'd100_000_000
) (
    input  logic           clk_i,
    input  logic           arst_i,
    input  logic           stb_rdy_i,
    input  logic           stb_i,
    input  logic           cmp_i,
    stb_sampler_if.slave   ctl
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT_RDY,
        SAMPLE,
        FINISH
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t               state;
    logic                 cmp_m;
    logic                 cmp_s;
    logic                 stb_d;
    logic                 stb_edge;
    logic [CNT_W-1:0]     n_req;
    logic [TIMEOUT_W-1:0] wd;
    logic [TIMEOUT_W-1:0] wd_next;
    logic [CNT_W-1:0]     total_next;

    assign stb_edge   = stb_i & ~stb_d;
    assign wd_next    = wd + 1'b1;
    assign total_next = ctl.total_cnt_o + 1'b1;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state           <= IDLE;
            cmp_m           <= 1'b0;
            cmp_s           <= 1'b0;
            stb_d           <= 1'b0;
            n_req           <= '0;
            wd              <= '0;
            ctl.busy_o      <= 1'b0;
            ctl.done_o      <= 1'b0;
            ctl.err_o       <= 1'b0;
            ctl.hit_cnt_o   <= '0;
            ctl.total_cnt_o <= '0;
        end else begin
            cmp_m      <= cmp_i;
            cmp_s      <= cmp_m;
            // stb_d follows the strobe in every state, so a strobe already
            // high when sampling starts is not mistaken for a fresh edge.
            stb_d      <= stb_i;
            ctl.done_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (ctl.start_i) begin
                        n_req           <= ctl.n_samples_i;
                        ctl.hit_cnt_o   <= '0;
                        ctl.total_cnt_o <= '0;
                        ctl.err_o       <= 1'b0;
                        ctl.busy_o      <= 1'b1;
                        wd              <= '0;
                        state           <= (ctl.n_samples_i == '0) ? FINISH : WAIT_RDY;
                    end
                end

                WAIT_RDY: begin
                    // Watchdog keeps running into SAMPLE; only an edge clears it.
                    wd <= wd_next;
                    if (stb_rdy_i) begin
                        state <= SAMPLE;
                    end else if (wd_next == WD_LAST) begin
                        ctl.err_o <= 1'b1;
                        state     <= FINISH;
                    end
                end

                SAMPLE: begin
                    // Losing lock wins over a coincident edge: counters hold.
                    if (!stb_rdy_i) begin
                        ctl.err_o <= 1'b1;
                        state     <= FINISH;
                    end else if (stb_edge) begin
                        wd              <= '0;
                        ctl.total_cnt_o <= total_next;
                        ctl.hit_cnt_o   <= ctl.hit_cnt_o + CNT_W'(cmp_s);
                        if (total_next == n_req) begin
                            state <= FINISH;
                        end
                    end else if (wd_next == WD_LAST) begin
                        wd        <= wd_next;
                        ctl.err_o <= 1'b1;
                        state     <= FINISH;
                    end else begin
                        wd <= wd_next;
                    end
                end

                FINISH: begin
                    ctl.done_o <= 1'b1;
                    ctl.busy_o <= 1'b0;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stb_sampler.sv
module tb_stb_sampler;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned TW    = 16;
    localparam int unsigned TO    = 64;

    logic clk = 1'b0;
    logic arst;
    logic stb_rdy;
    logic stb;
    logic cmp;

    stb_sampler_if #(.CNT_W(CNT_W)) bus ();

    stb_sampler #(
        .CNT_W          (CNT_W),
        .TIMEOUT_W      (TW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i     (clk),
        .arst_i    (arst),
        .stb_rdy_i (stb_rdy),
        .stb_i     (stb),
        .cmp_i     (cmp),
        .ctl       (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Done-pulse observer, sampled 1 time unit after each rising edge.
    int done_cnt  = 0;
    int done_cyc  = 0;
    bit prev_done = 1'b0;
    bit done_wide = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bus.done_o === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            if (prev_done) done_wide = 1'b1;
        end
        prev_done = (bus.done_o === 1'b1);
    end

    // Reference model: expected counts derived from the edges the bench drives.
    int m_req;
    int exp_total;
    int exp_hit;
    int rise_cyc;
    int start_cyc;
    bit chk_busy;
    int busy_bad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int n);
        m_req     = n;
        exp_total = 0;
        exp_hit   = 0;
    endtask

    task automatic do_start(input int n);
        bus.start_i     = 1'b1;
        bus.n_samples_i = CNT_W'(n);
        start_cyc       = cyc;
        @(negedge clk);
        bus.start_i     = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (chk_busy && bus.busy_o !== 1'b1) busy_bad++;
        end
    endtask

    // cmp settles for 3 cycles before the strobe rises so the synchronised
    // value is well defined on the edge cycle.
    task automatic strobe(input bit c, input int hi, input int lo);
        cmp = c;
        tick(3);
        stb      = 1'b1;
        rise_cyc = cyc;
        if (exp_total < m_req) begin
            exp_total++;
            exp_hit += int'(c);
        end
        tick(hi);
        stb = 1'b0;
        tick(lo);
    endtask

    task automatic wait_done(input int base, input int limit, input string tag);
        int t;
        t = 0;
        while (done_cnt == base && t < limit) begin
            @(negedge clk);
            t++;
        end
        check(tag, 64'(done_cnt != base), 64'd1);
    endtask

    int base;
    int n_rand;

    initial begin
        arst            = 1'b1;
        stb_rdy         = 1'b0;
        stb             = 1'b0;
        cmp             = 1'b0;
        bus.start_i     = 1'b0;
        bus.n_samples_i = '0;
        chk_busy        = 1'b0;
        busy_bad        = 0;
        model_reset(0);
        repeat (2) @(negedge clk);
        arst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy",  bus.busy_o,      0);
        check("rst_done",  bus.done_o,      0);
        check("rst_err",   bus.err_o,       0);
        check("rst_hit",   bus.hit_cnt_o,   0);
        check("rst_total", bus.total_cnt_o, 0);

        // Period-20 strobe, cmp constantly 1, 100 samples; lock arrives late.
        base = done_cnt;
        model_reset(100);
        do_start(100);
        check("t1_busy_start", bus.busy_o, 1);
        chk_busy = 1'b1;
        tick(10);
        stb_rdy = 1'b1;
        for (int i = 0; i < 99; i++) strobe(1'b1, 10, 7);
        chk_busy = 1'b0;
        strobe(1'b1, 10, 7);
        wait_done(base, 100, "t1_done");
        check("t1_latency",   done_cyc - rise_cyc, 2);
        check("t1_busy_thru", busy_bad, 0);
        check("t1_hit",       bus.hit_cnt_o,   exp_hit);
        check("t1_total",     bus.total_cnt_o, exp_total);
        check("t1_err",       bus.err_o,       0);
        check("t1_busy_end",  bus.busy_o,      0);
        tick(5);
        check("t1_hold_total", bus.total_cnt_o, 100);

        // Zero-length request finishes without any strobe.
        base = done_cnt;
        model_reset(0);
        do_start(0);
        wait_done(base, 20, "t3_done");
        check("t3_latency", done_cyc - start_cyc, 2);
        check("t3_hit",     bus.hit_cnt_o,   0);
        check("t3_total",   bus.total_cnt_o, 0);
        check("t3_err",     bus.err_o,       0);

        // Every 4th edge samples 0, 1000 samples, random strobe shape.
        base      = done_cnt;
        done_wide = 1'b0;
        model_reset(1000);
        do_start(1000);
        for (int i = 0; i < 1000; i++)
            strobe((i % 4) != 3, $urandom_range(1, 3), $urandom_range(1, 3));
        wait_done(base, 100, "t2_done");
        check("t2_hit",     bus.hit_cnt_o,   exp_hit);
        check("t2_hit750",  bus.hit_cnt_o,   750);
        check("t2_total",   bus.total_cnt_o, exp_total);
        check("t2_single",  done_wide,       0);
        check("t2_err",     bus.err_o,       0);

        // Random comparator data and random request length.
        base   = done_cnt;
        n_rand = $urandom_range(20, 60);
        model_reset(n_rand);
        do_start(n_rand);
        for (int i = 0; i < n_rand; i++)
            strobe(1'($urandom), $urandom_range(1, 4), $urandom_range(1, 4));
        wait_done(base, 100, "tr_done");
        check("tr_latency", done_cyc - rise_cyc, 2);
        check("tr_hit",     bus.hit_cnt_o,   exp_hit);
        check("tr_total",   bus.total_cnt_o, exp_total);

        // Strobe stops after 5 of 10 edges: watchdog expiry.
        base = done_cnt;
        model_reset(10);
        do_start(10);
        for (int i = 0; i < 5; i++) strobe(1'($urandom), 2, 2);
        wait_done(base, 300, "t4_done");
        check("t4_latency", done_cyc - rise_cyc, TO + 1);
        check("t4_err",     bus.err_o,       1);
        check("t4_total",   bus.total_cnt_o, 5);
        check("t4_hit",     bus.hit_cnt_o,   exp_hit);

        // Lock lost after 3 of 8 edges; a start while busy must be ignored.
        base = done_cnt;
        model_reset(8);
        do_start(8);
        strobe(1'b1, 2, 2);
        do_start(2);
        strobe(1'b0, 2, 2);
        strobe(1'b1, 2, 2);
        cmp = 1'b1;
        tick(3);
        stb_rdy  = 1'b0;
        stb      = 1'b1;
        rise_cyc = cyc;
        wait_done(base, 20, "t5_done");
        stb = 1'b0;
        check("t5_latency", done_cyc - rise_cyc, 2);
        check("t5_err",     bus.err_o,       1);
        check("t5_total",   bus.total_cnt_o, exp_total);
        check("t5_hit",     bus.hit_cnt_o,   exp_hit);
        stb_rdy = 1'b1;
        tick(3);

        // Asynchronous reset mid-acquisition, then a clean 4-sample run.
        model_reset(10);
        do_start(10);
        for (int i = 0; i < 3; i++) strobe(1'b1, 2, 2);
        base = done_cnt;
        @(negedge clk);
        #2 arst = 1'b1;
        #1;
        check("t6_busy",  bus.busy_o,      0);
        check("t6_done",  bus.done_o,      0);
        check("t6_err",   bus.err_o,       0);
        check("t6_hit",   bus.hit_cnt_o,   0);
        check("t6_total", bus.total_cnt_o, 0);
        @(negedge clk);
        arst = 1'b0;
        tick(3);
        check("t6_no_done", done_cnt, base);
        base = done_cnt;
        model_reset(4);
        do_start(4);
        for (int i = 0; i < 4; i++) strobe(1'($urandom), 2, 2);
        wait_done(base, 50, "t6_done2");
        check("t6_total2", bus.total_cnt_o, 4);
        check("t6_hit2",   bus.hit_cnt_o,   exp_hit);
        check("t6_err2",   bus.err_o,       0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
